fetch_unit: RTL

Instruction fetch stage sitting between the program BRAM (port A) and the control FSM's decode step. It owns the program counter, streams sequential instruction reads from BRAM, and buffers returned words in a 2-entry queue. It hands each word to the FSM through a valid/ready handshake and flushes on a branch/jump redirect from execute.

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 87 ++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: BRAM port A request/response plus the decode-side
// valid/ready handshake and the execute-side redirect.
interface fetch_unit_if #(
   parameter int ADDR_W = 16,
   parameter int INST_W = 16
);
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [INST_W-1:0] mem_q;
   logic [INST_W-1:0] inst;
   logic [ADDR_W-1:0] inst_pc;
   logic              inst_valid;
   logic              inst_ready;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic [ADDR_W-1:0] pc_value;

   modport master (
      output mem_addr, mem_rd, inst, inst_pc, inst_valid, pc_value,
      input  mem_q, inst_ready, redirect, redirect_pc
   );

   modport slave (
      input  mem_addr, mem_rd, inst, inst_pc, inst_valid, pc_value,
      output mem_q, inst_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, streams reads from program BRAM with a
// credit limit of two, buffers words in a 2-entry queue and flushes on redirect.
module fetch_unit #(
   parameter int              ADDR_W   = 16,
   parameter int              INST_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
   input  logic              clk,
   input  logic              rst,
   fetch_unit_if.master      bus
);
   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] issue_pc_r;
   logic [1:0]        count_r;
   logic              inflight_r;
   logic              squash_r;
   logic [INST_W-1:0] head_inst_r;
   logic [ADDR_W-1:0] head_pc_r;
   logic [INST_W-1:0] tail_inst_r;
   logic [ADDR_W-1:0] tail_pc_r;

   logic pop_s;
   logic push_s;
   logic credit_s;
   logic issue_s;
   logic fill_head_s;

   // Handshake, credit and queue-steering decisions for this cycle.
   always_comb begin
      pop_s       = (count_r != 2'd0) & bus.inst_ready & ~bus.redirect;
      push_s      = inflight_r & ~squash_r & ~bus.redirect;
      // Occupancy after this cycle's pop, including the word still in flight.
      credit_s    = (({1'b0, count_r} + {2'b00, inflight_r}) < (3'd2 + {2'b00, pop_s}));
      issue_s     = rst & ~bus.redirect & credit_s;
      fill_head_s = push_s & ((count_r == 2'd0) | ((count_r == 2'd1) & pop_s));
   end

   // PC, in-flight tracking and the two queue slots; redirect overrides everything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_r        <= RESET_PC;
         issue_pc_r  <= {ADDR_W{1'b0}};
         count_r     <= 2'd0;
         inflight_r  <= 1'b0;
         squash_r    <= 1'b0;
         head_inst_r <= {INST_W{1'b0}};
         head_pc_r   <= {ADDR_W{1'b0}};
         tail_inst_r <= {INST_W{1'b0}};
         tail_pc_r   <= {ADDR_W{1'b0}};
      end else if (bus.redirect) begin
         count_r    <= 2'd0;
         squash_r   <= inflight_r;
         inflight_r <= 1'b0;
         pc_r       <= bus.redirect_pc;
      end else begin
         squash_r   <= 1'b0;
         inflight_r <= issue_s;
         if (issue_s) begin
            pc_r       <= pc_r + PC_ONE;
            issue_pc_r <= pc_r;
         end
         count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
         if (pop_s) begin
            head_inst_r <= tail_inst_r;
            head_pc_r   <= tail_pc_r;
         end
         // A response lands in the head when the queue is (or is about to be) empty.
         if (fill_head_s) begin
            head_inst_r <= bus.mem_q;
            head_pc_r   <= issue_pc_r;
         end else if (push_s) begin
            tail_inst_r <= bus.mem_q;
            tail_pc_r   <= issue_pc_r;
         end
      end
   end

   assign bus.mem_addr   = pc_r;
   assign bus.pc_value   = pc_r;
   assign bus.mem_rd     = issue_s;
   assign bus.inst       = head_inst_r;
   assign bus.inst_pc    = head_pc_r;
   assign bus.inst_valid = (count_r != 2'd0);

endmodule
